// File: rtl/haraka_s_pkg.sv
// Shared types for the Haraka-S sponge datapath.
// Holds the squeeze FSM encoding and block geometry.
package haraka_s_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    EMIT,
    REQ,
    FIN
  } squeeze_state_t;

  localparam int BLOCK_BYTES = 32;
  localparam int BYTE_IDX_W  = 5;

endpackage

// File: rtl/digest_squeezer.sv
// Streams digest bytes out of 256-bit rate blocks, MSB byte first.
// Optional: SQUEEZE_PARTIAL_MASK_EN masks the unused bits of the final byte.
module digest_squeezer
  import haraka_s_pkg::*;
#(
  parameter int BLOCK_BITS = 256,
  parameter int BYTE_BITS  = 8
) (
  input  logic                  internal_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [63:0]           digest_length,
  input  logic [BLOCK_BITS-1:0] block_in,
  input  logic                  block_valid,
  output logic                  block_ready,
  output logic                  perm_req,
  output logic [BYTE_BITS-1:0]  byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  byte_last,
  output logic                  busy,
  output logic                  done
);

  localparam int REM_W = 62;
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX =
    BYTE_IDX_W'(BLOCK_BITS / BYTE_BITS - 1);

  squeeze_state_t        state_q, state_d;
  logic [REM_W-1:0]      remaining_q, remaining_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [BLOCK_BITS-1:0] shift_q, shift_d;

  logic [REM_W-1:0]      total_bytes;
  logic [BYTE_BITS-1:0]  head;
  logic [BYTE_BITS-1:0]  out_byte;
  logic                  last_byte;
  logic                  emit_hs;

  // ceil(len/8) without a carry out of 64 bits, even at len = 2^64-1
  assign total_bytes = {1'b0, digest_length[63:3]}
                     + REM_W'(|digest_length[2:0]);

  assign head      = shift_q[BLOCK_BITS-1 -: BYTE_BITS];
  assign last_byte = (remaining_q == REM_W'(1));
  assign emit_hs   = (state_q == EMIT) && byte_ready;

`ifdef SQUEEZE_PARTIAL_MASK_EN
  logic [2:0] tail_q, tail_d;

  always_comb begin
    out_byte = head;
    if (last_byte && (tail_q != 3'd0)) begin
      out_byte = head & ~({BYTE_BITS{1'b1}} >> tail_q);
    end
  end

  always_comb begin
    tail_d = tail_q;
    if ((state_q == IDLE) && start) begin
      tail_d = digest_length[2:0];
    end
  end

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      tail_q <= '0;
    end else begin
      tail_q <= tail_d;
    end
  end
`else
  assign out_byte = head;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = total_bytes;
          state_d     = (total_bytes == '0) ? FIN : WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        if (block_valid) begin
          shift_d = block_in;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (emit_hs) begin
          shift_d     = shift_q << BYTE_BITS;
          idx_d       = idx_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (last_byte) begin
            state_d = FIN;
          end else if (idx_q == LAST_IDX) begin
            state_d = REQ;
          end
        end
      end
      REQ: state_d = WAIT_BLK;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
    end
  end

  assign block_ready = (state_q == WAIT_BLK);
  assign byte_valid  = (state_q == EMIT);
  assign perm_req    = (state_q == REQ);
  assign done        = (state_q == FIN);
  assign busy        = (state_q != IDLE);
  assign byte_out    = byte_valid ? out_byte : '0;
  assign byte_last   = byte_valid && last_byte;

endmodule

// File: tb/tb_digest_squeezer.sv
// Randomised bench for digest_squeezer against a byte-stream model.
// Build with SQUEEZE_PARTIAL_MASK_EN to match a masked DUT.
module tb_digest_squeezer;

  logic         internal_clk = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  digest_length;
  logic [255:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic         perm_req;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_last;
  logic         busy;
  logic         done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  digest_squeezer dut (
    .internal_clk (internal_clk),
    .reset        (reset),
    .start        (start),
    .digest_length(digest_length),
    .block_in     (block_in),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .perm_req     (perm_req),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_last    (byte_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 internal_clk = ~internal_clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, byte_valid, 0);
    check({tag, "_byte"}, byte_out, 0);
    check({tag, "_last"}, byte_last, 0);
    check({tag, "_bready"}, block_ready, 0);
    check({tag, "_perm"}, perm_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // fill: 1 = counting bytes, 0 = random bytes
  // abort_after: assert reset once this many bytes have gone out
  // repulse_after: pulse start (len 8) right after this byte
  task automatic run(input logic [63:0] len, input int fill,
                     input int stall, input int abort_after,
                     input int repulse_after);
    logic [7:0] src[$];
    logic [7:0] exp[$];
    logic [7:0] b;
    logic [7:0] prev_b;
    logic       prev_l;
    logic       prev_stall;
    logic       saw_out;
    int total, nblk, n, blk, perms, acc, dones;
    int done_cyc, last_hs_cyc, k;

    total = int'((len + 64'd7) >> 3);
    nblk  = (total + 31) / 32;
    for (int i = 0; i < nblk * 32; i++)
      src.push_back(fill != 0 ? 8'(i) : 8'($urandom));
    if (len == 64'd300) src[37] = 8'hAB;
    for (int i = 0; i < total; i++) exp.push_back(src[i]);
`ifdef SQUEEZE_PARTIAL_MASK_EN
    k = int'(len % 64'd8);
    if (total > 0 && k != 0) begin
      b = exp[total-1];
      exp[total-1] = (b >> (8 - k)) << (8 - k);
    end
`endif

    n = 0; blk = 0; perms = 0; acc = 0; dones = 0;
    done_cyc = -1; last_hs_cyc = -1;
    prev_stall = 1'b0; prev_b = '0; prev_l = 1'b0;
    saw_out = 1'b0;

    @(negedge internal_clk);
    digest_length = len;
    start         = 1'b1;
    block_valid   = 1'b1;
    byte_ready    = 1'b0;
    for (int j = 0; j < 32; j++)
      block_in[255 - 8*j -: 8] = (nblk > 0) ? src[j] : 8'($urandom);

    for (int cyc = 1; cyc < 4000; cyc++) begin
      @(negedge internal_clk);
      start = 1'b0;
      if (byte_valid || block_ready || perm_req) saw_out = 1'b1;
      if (perm_req) perms++;
      if (prev_stall) begin
        check("hold_valid", byte_valid, 1);
        check("hold_byte", byte_out, prev_b);
        check("hold_last", byte_last, prev_l);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        break;
      end
      if (abort_after >= 0 && n == abort_after) begin
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        repeat (3) begin
          @(negedge internal_clk);
          check("abort_no_done", done, 0);
          check("abort_no_valid", byte_valid, 0);
        end
        reset = 1'b0;
        return;
      end

      byte_ready = ($urandom_range(0, 99) >= stall);
      for (int j = 0; j < 32; j++)
        block_in[255 - 8*j -: 8] =
          (blk < nblk) ? src[blk*32 + j] : 8'($urandom);

      if (byte_valid && byte_ready) begin
        check("byte", byte_out, (n < total) ? exp[n] : 8'hxx);
        check("last", byte_last, (n == total - 1));
        n++;
        last_hs_cyc = cyc;
        if (n == repulse_after) begin
          start         = 1'b1;
          digest_length = 64'd8;
        end
      end
      if (block_valid && block_ready) begin
        check("blk_after_perm", acc, perms);
        acc++;
        blk++;
      end
      prev_stall = byte_valid && !byte_ready;
      prev_b     = byte_out;
      prev_l     = byte_last;
    end

    check("done_seen", dones, 1);
    check("n_bytes", n, total);
    check("perm_count", perms, (nblk > 0) ? nblk - 1 : 0);
    check("accepts", acc, nblk);
    if (total == 0) begin
      check("zero_no_out", saw_out, 0);
      check("zero_latency", (done_cyc >= 1 && done_cyc <= 2), 1);
    end else begin
      check("done_after_last", done_cyc, last_hs_cyc + 1);
    end
    @(negedge internal_clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    digest_length = '0;
    block_in      = '0;
    block_valid   = 1'b0;
    byte_ready    = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge internal_clk);
    reset = 1'b0;

    run(64'd256, 1, 0, -1, -1);
    run(64'd0, 0, 0, -1, -1);
    run(64'd300, 1, 0, -1, -1);
    run(64'd512, 0, 50, -1, -1);
    run(64'd256, 1, 0, 10, -1);
    run(64'd8, 0, 0, -1, -1);
    run(64'd100, 0, 20, -1, 3);
    for (int t = 0; t < 4; t++)
      run(64'($urandom_range(1, 700)), 0, 30, -1, -1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
